// File: rtl/loader_pkg.sv
// Shared types and default sizing for the SAP serial program loader.
package loader_pkg;

    localparam int DEPTH_DEFAULT = 16;
    localparam int ADR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } load_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first. Synchronizes rx, times bits from the
// start edge, and reports each frame as a 1-cycle byte_valid or frame_bad.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_bad
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // Last cycle of the half-bit wait to the middle of the start bit.
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    // Last cycle of a full bit period.
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;

    assign byte_data = shift_q;

    // Receiver next-state: bit timing, sampling and frame outcome pulses.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
        rx_meta_d  = rx;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_bad  = 1'b0;

        if (!enable) begin
            state_d   = RX_IDLE;
            cnt_d     = '0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                RX_IDLE: begin
                    // A high-to-low transition only; a line stuck low after a bad stop bit does not re-arm.
                    if (rx_prev_q && !rx_sync_q) begin
                        state_d   = RX_START;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_END) begin
                        cnt_d   = '0;
                        // Line back high at mid start bit is a glitch: drop it silently.
                        state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_END) begin
                        cnt_d     = '0;
                        shift_d   = {rx_sync_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = RX_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_END) begin
                        cnt_d      = '0;
                        state_d    = RX_IDLE;
                        byte_valid = rx_sync_q;
                        frame_bad  = !rx_sync_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // Receiver registers; the synchronizer resets to the idle-high line level.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RX_IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, like real hardware.
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            rx_prev_q <= rx_prev_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: writes DEPTH received bytes to consecutive memory
// addresses starting at 0, driving the memory write port directly.
module program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int ADR_W        = ADR_W_DEFAULT
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic             start,
    output logic             mem_write,
    output logic             mem_clken,
    output logic [ADR_W-1:0] mem_adr,
    output logic [7:0]       mem_data,
    output logic             busy,
    output logic             done,
    output logic             frame_err
);

    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 1);

    load_state_e      state_q, state_d;
    logic             mem_write_q, mem_write_d;
    logic [ADR_W-1:0] mem_adr_q, mem_adr_d;
    logic [7:0]       mem_data_q, mem_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             frame_err_q, frame_err_d;

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             frame_bad;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .enable    (state_q == LOAD),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_bad (frame_bad)
    );

    assign mem_write = mem_write_q;
    assign mem_clken = mem_write_q;
    assign mem_adr   = mem_adr_q;
    assign mem_data  = mem_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;

    // Load sequencing: accept start, turn each valid byte into one write, then advance the address.
    always_comb begin
        state_d     = state_q;
        mem_write_d = 1'b0;
        mem_adr_d   = mem_adr_q;
        mem_data_d  = mem_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        frame_err_d = frame_err_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = LOAD;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    frame_err_d = 1'b0;
                    mem_adr_d   = '0;
                end
            end
            LOAD: begin
                if (byte_valid) begin
                    mem_write_d = 1'b1;
                    mem_data_d  = byte_data;
                end
                if (frame_bad) begin
                    frame_err_d = 1'b1;
                end
                // The address moves only after the strobe cycle, so it is stable during the write.
                if (mem_write_q) begin
                    if (mem_adr_q == LAST_ADR) begin
                        state_d   = DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        mem_adr_d = '0;
                    end else begin
                        mem_adr_d = mem_adr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load FSM and output registers.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mem_write_q <= 1'b0;
            mem_adr_q   <= '0;
            mem_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_write_q <= mem_write_d;
            mem_adr_q   <= mem_adr_d;
            mem_data_q  <= mem_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with CLKS_PER_BIT=4, DEPTH=16.
// Expected writes are queued as bytes are sent and compared by a monitor.
module tb_program_loader;

    localparam int CPB = 4;

    typedef struct packed {
        logic [3:0] adr;
        logic [7:0] data;
    } wr_t;

    localparam logic [7:0] TBL [16] = '{
        8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h14, 8'h05, 8'h0E,
        8'h1D, 8'h2C, 8'h3F, 8'h4A, 8'h5B, 8'h6C, 8'h02, 8'h01
    };

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       start = 1'b0;
    logic       mem_write;
    logic       mem_clken;
    logic [3:0] mem_adr;
    logic [7:0] mem_data;
    logic       busy;
    logic       done;
    logic       frame_err;

    wr_t        exp_q[$];
    wr_t        exp_w;
    logic [3:0] exp_adr = '0;
    logic       prev_write = 1'b0;
    int         checks = 0;
    int         errors = 0;

    program_loader #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (16),
        .ADR_W       (4)
    ) dut (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .rx       (rx),
        .start    (start),
        .mem_write(mem_write),
        .mem_clken(mem_clken),
        .mem_adr  (mem_adr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .frame_err(frame_err)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete within 1 ms");
        $fatal(1, "timeout");
    end

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge sysclk) begin
        if (reset_n) begin
            checks++;
            if (mem_clken !== mem_write) begin
                errors++;
                $display("FAIL clken_eq_write: mem_clken=%b mem_write=%b", mem_clken, mem_write);
            end
            if (mem_write === 1'b1) begin
                checks++;
                if (prev_write) begin
                    errors++;
                    $display("FAIL strobe_width: mem_write high for more than one cycle at adr=%0d", mem_adr);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: adr=%0d data=%h, none expected", mem_adr, mem_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (mem_adr !== exp_w.adr || mem_data !== exp_w.data) begin
                        errors++;
                        $display("FAIL write_content: got adr=%0d data=%h, expected adr=%0d data=%h",
                                 mem_adr, mem_data, exp_w.adr, exp_w.data);
                    end
                end
            end
        end
        prev_write = mem_write;
    end

    task automatic reset_dut();
        reset_n = 1'b0;
        rx      = 1'b1;
        start   = 1'b0;
        exp_q.delete();
        exp_adr = '0;
        repeat (3) @(posedge sysclk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge sysclk);
        #1 start = 1'b1;
        @(posedge sysclk);
        #1 start = 1'b0;
    endtask

    // Drive one 8N1 frame; queue the write when one is expected.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input bit expect_write);
        if (expect_write) begin
            exp_q.push_back('{adr: exp_adr, data: d});
            exp_adr = exp_adr + 4'd1;
        end
        @(posedge sysclk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge sysclk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (CPB) @(posedge sysclk);
        end
        #1 rx = stop_bit;
        repeat (CPB) @(posedge sysclk);
        #1 rx = 1'b1;
        repeat (2 * CPB) @(posedge sysclk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge sysclk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected writes never appeared", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({mem_write, mem_clken, mem_adr, mem_data, busy, done, frame_err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {mem_write, mem_clken, mem_adr, mem_data, busy, done, frame_err});
        end
        repeat (200) @(posedge sysclk);
        // A byte with no load in progress must be ignored.
        send_byte(8'hA5, 1'b1, 0);
        checks++;
        if ({busy, done, mem_adr} !== 6'd0) begin
            errors++;
            $display("FAIL idle_state: busy=%b done=%b adr=%0d, expected 0 0 0", busy, done, mem_adr);
        end
    endtask

    task automatic test_full_load();
        reset_dut();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_busy: busy=%b done=%b, expected 1 0", busy, done);
        end
        for (int i = 0; i < 16; i++) begin
            send_byte(TBL[i], 1'b1, 1);
        end
        wait_drain("full_load");
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_adr !== 4'd0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL load_done: done=%b busy=%b adr=%0d ferr=%b, expected 1 0 0 0",
                     done, busy, mem_adr, frame_err);
        end
        // Bytes in DONE are ignored.
        send_byte(8'h77, 1'b1, 0);
        checks++;
        if (done !== 1'b1 || mem_adr !== 4'd0) begin
            errors++;
            $display("FAIL done_ignore: done=%b adr=%0d, expected 1 0", done, mem_adr);
        end
    endtask

    task automatic test_frame_err();
        reset_dut();
        pulse_start();
        send_byte(8'h55, 1'b0, 0);
        checks++;
        if (frame_err !== 1'b1 || mem_adr !== 4'd0) begin
            errors++;
            $display("FAIL frame_err_set: ferr=%b adr=%0d, expected 1 0", frame_err, mem_adr);
        end
        send_byte(8'hAA, 1'b1, 1);
        wait_drain("frame_err");
        checks++;
        if (frame_err !== 1'b1 || mem_adr !== 4'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_after: ferr=%b adr=%0d busy=%b, expected 1 1 1",
                     frame_err, mem_adr, busy);
        end
    endtask

    task automatic test_glitch();
        reset_dut();
        pulse_start();
        @(posedge sysclk);
        #1 rx = 1'b0;
        @(posedge sysclk);
        #1 rx = 1'b1;
        repeat (20) @(posedge sysclk);
        #1;
        checks++;
        if (frame_err !== 1'b0 || mem_adr !== 4'd0) begin
            errors++;
            $display("FAIL glitch: ferr=%b adr=%0d, expected 0 0", frame_err, mem_adr);
        end
        send_byte(8'h7E, 1'b1, 1);
        wait_drain("glitch");
        checks++;
        if (mem_adr !== 4'd1) begin
            errors++;
            $display("FAIL glitch_next: adr=%0d, expected 1", mem_adr);
        end
    endtask

    task automatic test_start_restart();
        reset_dut();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 9) pulse_start();
            if (i == 5) send_byte(8'h33, 1'b0, 0);
            send_byte(TBL[15 - i], 1'b1, 1);
        end
        wait_drain("restart_load");
        checks++;
        if (done !== 1'b1 || frame_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_done: done=%b ferr=%b busy=%b, expected 1 1 0", done, frame_err, busy);
        end
        pulse_start();
        checks++;
        if (done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b1 || mem_adr !== 4'd0) begin
            errors++;
            $display("FAIL restart_clear: done=%b ferr=%b busy=%b adr=%0d, expected 0 0 1 0",
                     done, frame_err, busy, mem_adr);
        end
        exp_adr = '0;
        send_byte(8'h5A, 1'b1, 1);
        wait_drain("restart_byte");
    endtask

    task automatic test_reset_mid_byte();
        reset_dut();
        pulse_start();
        send_byte(8'h11, 1'b1, 1);
        send_byte(8'h22, 1'b1, 1);
        wait_drain("mid_byte_pre");
        @(posedge sysclk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge sysclk);
        for (int i = 0; i < 4; i++) begin
            #1 rx = 1'b1;
            repeat (CPB) @(posedge sysclk);
        end
        #1 rx = 1'b0;
        repeat (2) @(posedge sysclk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_write, mem_clken, mem_adr, mem_data, busy, done, frame_err} !== 17'd0) begin
            errors++;
            $display("FAIL mid_byte_reset: got %b, expected all zero",
                     {mem_write, mem_clken, mem_adr, mem_data, busy, done, frame_err});
        end
        repeat (3) @(posedge sysclk);
        #1 rx = 1'b1;
        reset_n = 1'b1;
        exp_adr = '0;
        repeat (4) @(posedge sysclk);
        pulse_start();
        send_byte(8'h3C, 1'b1, 1);
        wait_drain("mid_byte_post");
        checks++;
        if (mem_adr !== 4'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_byte_resume: adr=%0d busy=%b, expected 1 1", mem_adr, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_frame_err();
        test_glitch();
        test_start_restart();
        test_reset_mid_byte();
        repeat (5) @(posedge sysclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Serial program loader for the 16-byte SAP memory. It receives bytes over a UART line (8N1, LSB first) and writes them to consecutive memory addresses, 0 through 15. It sits directly upstream of the memory's write port, driving its write, clock-enable, address and data inputs. The CPU is held off by the integrator while `busy` is high.

## Interface
- `CLKS_PER_BIT`, default 1250: sysclk cycles per UART bit (12 MHz / 9600 baud); must be ≥ 4.
- `DEPTH`, default 16: number of bytes per load; equals the memory size.
- `ADR_W`, default 4: memory address width; `DEPTH` = 2^`ADR_W`.

Ports:
- `sysclk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART serial input, idle high; asynchronous to sysclk.
- `start`  in  1  single-cycle request to begin a load; ignored while `busy`.
- `mem_write`  out  1  one-cycle write strobe to memory `write`.
- `mem_clken`  out  1  memory clock enable; identical to `mem_write`.
- `mem_adr`  out  ADR_W  memory address.
- `mem_data`  out  8  byte to write.
- `busy`  out  1  high from accepted `start` until the last byte is written.
- `done`  out  1  high after a complete load, until the next accepted `start`.
- `frame_err`  out  1  sticky; set on a bad stop bit, cleared by an accepted `start`.

## Operation
- Reset values: `mem_write`=0, `mem_clken`=0, `mem_adr`=0, `mem_data`=0, `busy`=0, `done`=0, `frame_err`=0. Both FSMs return to IDLE.
- `rx` passes through a 2-flop synchronizer (reset value 1) before any use.

Load FSM:
- IDLE: `start` moves to LOAD; sets `busy`=1, clears `done` and `frame_err`, sets `mem_adr`=0.
- LOAD: each valid byte from the receiver produces one write pulse, then `mem_adr` increments.
- After the write to address DEPTH-1 → DONE; `busy`=0, `done`=1, `mem_adr` wraps to 0.
- DONE: `start` → LOAD, with the same clears as from IDLE.

Receiver FSM (enabled only in LOAD):
- RX_IDLE: a falling edge on synchronized `rx` → RX_START and clears the bit counter.
- RX_START: at cycle CLKS_PER_BIT/2 (integer division), sample `rx`. If 0 → RX_DATA. If 1 (glitch) → RX_IDLE silently, no error.
- RX_DATA: sample every CLKS_PER_BIT cycles, 8 bits, shifting LSB first into bit 0 → bit 7. After bit 7 → RX_STOP.
- RX_STOP: sample after CLKS_PER_BIT cycles.
  - 1: byte valid.
  - 0: `frame_err`=1, byte discarded, `mem_adr` unchanged, no write.
  - Either way → RX_IDLE, which waits for `rx` high before arming for the next falling edge.

Boundary conditions:
- `start` while `busy`: ignored.
- A partially received frame when the load completes: impossible, since the load completes only on a write.
- Bytes arriving in IDLE or DONE: ignored entirely, no writes.
- `reset_n` low mid-byte or mid-load: immediate abort. The partial byte is lost and the memory is not written again. Memory already written keeps its contents.

## Timing
- Valid byte path:
  - Cycle N: stop-bit sample; `mem_data` loaded.
  - Cycle N+1: `mem_write`=`mem_clken`=1 for exactly one cycle, with `mem_adr` and `mem_data` stable.
  - Cycle N+2: `mem_adr` advances.
- `busy` falls and `done` rises in cycle N+2 of the last byte.
- `mem_data` holds its last value between writes.
- End-to-end latency from the `rx` start edge to the write strobe: 2 (synchronizer) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles.
- The memory captures data on the sysclk edge at the end of cycle N+1.

## Structure
- Package `loader_pkg`:
  - load-state enum: IDLE, LOAD, DONE;
  - receiver-state enum: RX_IDLE, RX_START, RX_DATA, RX_STOP;
  - `DEPTH_DEFAULT`, `ADR_W_DEFAULT`.
- Sub-module `uart_rx_byte`, which contains:
  - the synchronizer, bit-timing counter and shift register;
  - outputs `byte_valid` (1-cycle pulse in cycle N), `byte_data[7:0]` and `frame_bad` (1-cycle pulse);
  - input `enable` (held 0 forces RX_IDLE).
- `program_loader` holds the load FSM, address counter and output registers.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DEPTH=16.
- Reset then idle: outputs all 0, `rx`=1, no `start` for 200 cycles → no `mem_write` ever.
- Full load: `start`, then bytes 0x09, 0x1A, 0x2B, 0xE0, 0xF0, 0x14, 0x05…0x01 (16 total) → 16 single-cycle strobes at addresses 0–15 in order with matching data; `done`=1, `busy`=0, `mem_adr`=0 after the last.
- Framing error: after `start`, send byte 0x55 with stop bit 0, then 0xAA valid → `frame_err`=1, one write only, 0xAA to address 0.
- Glitch: 1-cycle low pulse on `rx` during LOAD → no write, no `frame_err`, next valid byte goes to address 0.
- Start ignored and restart:
  - `start` pulsed mid-load → no effect on address sequence;
  - `start` in DONE → `done`=0, `frame_err` cleared, next byte to address 0.
- Reset mid-byte: `reset_n` low during data bit 4 of the 3rd byte → all outputs 0 at once. After release, `start` + 0x3C writes 0x3C to address 0.
